sh_sync_sched: RTL

//  Mode scheduler for the SH_SYNC sample/hold pulse generator. Owns its RX and tx_rdy inputs:

---
 rtl/sh_sync_pkg.sv | 31 +++
 rtl/sh_sched_timer.sv | 28 ++
 rtl/sh_sync_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sh_sync_pkg.sv
// Shared state encodings and SH_SYNC timing constants for the SH_SYNC mode scheduler.
// Also holds the small helpers used when sizing and counting in the scheduler.
package sh_sync_pkg;

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_RX_LISTEN = 3'd1;
  localparam logic [2:0] ST_RX_SYNC   = 3'd2;
  localparam logic [2:0] ST_TX_SETUP  = 3'd3;
  localparam logic [2:0] ST_TX_ACTIVE = 3'd4;
  localparam logic [2:0] ST_TX_GUARD  = 3'd5;
  localparam logic [2:0] ST_ERROR     = 3'd6;

  // SH_SYNC's own edge timeout and TX pulse interval, in clk cycles.
  localparam int SH_TIMEOUT_CYC     = 20000;
  localparam int SH_TX_INTERVAL_CYC = 10000;

  // Listen for ten SH_SYNC timeouts; the pulse watchdog sits half a TX interval past SH_SYNC's timeout.
  localparam int LISTEN_TO_DFLT  = 10 * SH_TIMEOUT_CYC;
  localparam int PULSE_WDOG_DFLT = SH_TIMEOUT_CYC + SH_TX_INTERVAL_CYC / 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    return (v == 7'h7f) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/sh_sched_timer.sv
// Loadable down-counter for the scheduler. It holds at zero.
// Expired is the cycle the count reads zero.
module sh_sched_timer #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/sh_sync_sched.sv
// Mode scheduler for SH_SYNC: alternates RX listen/sync windows with TX bursts,
// supervises sh_en/fsm_rst with watchdogs and tracks consecutive sync failures.
//
//  state        | meaning
//  -------------+-------------------------------------------------------------
//  OFF          | idle, waiting for enable
//  RX_LISTEN    | receive mode, waiting for fsm_rst or the listen timeout
//  RX_SYNC      | counting sh_en pulses of a sync run under the pulse watchdog
//  TX_SETUP     | RX dropped, tx_rdy still low while SH_SYNC settles
//  TX_ACTIVE    | tx_rdy high, counting burst pulses under the pulse watchdog
//  TX_GUARD     | back in receive mode, quiet period before listening
//  ERROR        | too many consecutive sync failures; waits for clr_err
module sh_sync_sched
  import sh_sync_pkg::*;
#(
  parameter int LISTEN_TO   = LISTEN_TO_DFLT,
  parameter int SYNC_PULSES = 65,
  parameter int TX_PULSES   = 8,
  parameter int PULSE_WDOG  = PULSE_WDOG_DFLT,
  parameter int SETUP_CYC   = 4,
  parameter int GUARD_CYC   = 100,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tx_req,
  input  logic       clr_err,
  input  logic       sh_en,
  input  logic       fsm_rst,
  output logic       RX,
  output logic       tx_rdy,
  output logic       rx_done,
  output logic       tx_done,
  output logic       sync_err,
  output logic       err,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o
);

  localparam int TMAX = max3(LISTEN_TO, PULSE_WDOG, GUARD_CYC);
  localparam int TW   = $clog2(TMAX + 1);

  // An N-cycle window loads N-1 so that the Nth cycle in the window reads zero.
  localparam logic [TW-1:0] LD_LISTEN = TW'(LISTEN_TO - 1);
  localparam logic [TW-1:0] LD_WDOG   = TW'(PULSE_WDOG - 1);
  localparam logic [TW-1:0] LD_SETUP  = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] LD_GUARD  = TW'(GUARD_CYC - 1);

  localparam logic [6:0] SYNC_TGT  = 7'(SYNC_PULSES);
  localparam logic [6:0] TX_TGT    = 7'(TX_PULSES);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

  logic [2:0]    r_state;
  logic          r_rx;
  logic          r_tx_rdy;
  logic          r_rx_done;
  logic          r_tx_done;
  logic          r_sync_err;
  logic          r_err;
  logic [1:0]    r_retry;
  logic [6:0]    r_pcnt;

  logic [2:0]    w_next;
  logic          w_restart;
  logic          w_entry;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_dec;
  logic          w_expired;
  logic          w_counting;
  logic [6:0]    w_pcnt_inc;
  logic          w_sync_hit;
  logic          w_tx_hit;
  logic [1:0]    w_retry_inc;
  logic [1:0]    w_retry_next;
  logic          w_rx_done;
  logic          w_tx_done;
  logic          w_sync_err;

  assign w_pcnt_inc  = sat_inc7(r_pcnt);
  assign w_counting  = (r_state == ST_RX_SYNC) || (r_state == ST_TX_ACTIVE);
  assign w_sync_hit  = sh_en && (w_pcnt_inc == SYNC_TGT);
  assign w_tx_hit    = sh_en && (w_pcnt_inc == TX_TGT);
  assign w_retry_inc = (r_retry == RETRY_MAX) ? r_retry : r_retry + 2'd1;

  always_comb begin
    w_next       = r_state;
    w_restart    = 1'b0;
    w_rx_done    = 1'b0;
    w_tx_done    = 1'b0;
    w_sync_err   = 1'b0;
    w_retry_next = r_retry;

    if (!enable && (r_state != ST_ERROR)) begin
      w_next = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_next = ST_RX_LISTEN;
        end
        ST_RX_LISTEN: begin
          if (fsm_rst) begin
            w_next = ST_RX_SYNC;
          end else if (w_expired) begin
            if (tx_req) w_next = ST_TX_SETUP;
            else        w_restart = 1'b1;
          end
        end
        ST_RX_SYNC: begin
          // A pulse landing on the expiry cycle still completes the run.
          if (w_sync_hit) begin
            w_rx_done    = 1'b1;
            w_retry_next = 2'd0;
            w_next       = tx_req ? ST_TX_SETUP : ST_RX_LISTEN;
          end else if (w_expired) begin
            w_sync_err   = 1'b1;
            w_retry_next = w_retry_inc;
            w_next       = (w_retry_inc == RETRY_MAX) ? ST_ERROR : ST_RX_LISTEN;
          end else if (sh_en) begin
            w_restart = 1'b1;
          end
        end
        ST_TX_SETUP: begin
          if (w_expired) w_next = ST_TX_ACTIVE;
        end
        ST_TX_ACTIVE: begin
          if (w_tx_hit) begin
            w_tx_done = 1'b1;
            w_next    = ST_TX_GUARD;
          end else if (w_expired) begin
            w_sync_err = 1'b1;
            w_next     = ST_TX_GUARD;
          end else if (sh_en) begin
            w_restart = 1'b1;
          end
        end
        ST_TX_GUARD: begin
          if (w_expired) w_next = ST_RX_LISTEN;
        end
        ST_ERROR: begin
          if (clr_err) begin
            w_next       = ST_OFF;
            w_retry_next = 2'd0;
          end
        end
        default: begin
          w_next = ST_OFF;
        end
      endcase
    end
  end

  assign w_entry = (w_next != r_state);
  assign w_load  = w_entry || w_restart;
  assign w_dec   = (r_state != ST_OFF) && (r_state != ST_ERROR);

  always_comb begin
    w_load_val = '0;
    case (w_next)
      ST_RX_LISTEN: w_load_val = LD_LISTEN;
      ST_RX_SYNC:   w_load_val = LD_WDOG;
      ST_TX_SETUP:  w_load_val = LD_SETUP;
      ST_TX_ACTIVE: w_load_val = LD_WDOG;
      ST_TX_GUARD:  w_load_val = LD_GUARD;
      default:      w_load_val = '0;
    endcase
  end

  sh_sched_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_expired  (w_expired)
  );

  // Outputs are decoded from the next state so they change on the same edge as state_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_rx       <= 1'b1;
      r_tx_rdy   <= 1'b0;
      r_rx_done  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_sync_err <= 1'b0;
      r_err      <= 1'b0;
      r_retry    <= 2'd0;
      r_pcnt     <= 7'd0;
    end else begin
      r_state    <= w_next;
      r_rx       <= !((w_next == ST_TX_SETUP) || (w_next == ST_TX_ACTIVE));
      r_tx_rdy   <= (w_next == ST_TX_ACTIVE);
      r_rx_done  <= w_rx_done;
      r_tx_done  <= w_tx_done;
      r_sync_err <= w_sync_err;
      r_err      <= (w_next == ST_ERROR);
      r_retry    <= w_retry_next;
      if (w_entry) begin
        r_pcnt <= 7'd0;
      end else if (sh_en && w_counting) begin
        r_pcnt <= w_pcnt_inc;
      end
    end
  end

  assign RX        = r_rx;
  assign tx_rdy    = r_tx_rdy;
  assign rx_done   = r_rx_done;
  assign tx_done   = r_tx_done;
  assign sync_err  = r_sync_err;
  assign err       = r_err;
  assign retry_cnt = r_retry;
  assign state_o   = r_state;

endmodule
